// File: rtl/penalty_pkg.sv
// rtl/penalty_pkg.sv - shared state, keycode, aim and winner encodings for the penalty game
package penalty_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        AIM       = 3'd1,
        SHOOT     = 3'd2,
        RESULT    = 3'd3,
        GAME_OVER = 3'd4
    } game_state_e;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;

    localparam logic [1:0] AIM_CENTRE = 2'd0;
    localparam logic [1:0] AIM_LEFT   = 2'd1;
    localparam logic [1:0] AIM_RIGHT  = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_A    = 2'd1;
    localparam logic [1:0] WIN_B    = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    function automatic logic [1:0] winner_of(input logic [3:0] a, input logic [3:0] b);
        if (a > b)      return WIN_A;
        else if (b > a) return WIN_B;
        else            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - keycode history register with a one-cycle new-key pulse
module key_edge_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    output logic [7:0] key_code,
    output logic       key_edge
);

    logic [7:0] prev_q, prev_d;
    logic       edge_q, edge_d;

    always_comb begin
        prev_d = keycode;
        edge_d = (keycode != prev_q) && (keycode != 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 8'd0;
            edge_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    // prev_q holds the very code that produced edge_q
    assign key_code = prev_q;
    assign key_edge = edge_q;

endmodule

// File: rtl/penalty_game_ctrl.sv
// rtl/penalty_game_ctrl.sv - penalty shoot-out game FSM; PENALTY_SUDDEN_DEATH_EN enables sudden-death pairs
module penalty_game_ctrl
    import penalty_pkg::*;
#(
    parameter int NUM_ROUNDS    = 5,
    parameter int RESULT_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       reset_rtl_0,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       shot_done,
    input  logic       save_detect,
    output logic [2:0] game_state,
    output logic       kick_start,
    output logic [1:0] aim_dir,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic       kicker,
    output logic [1:0] winner
);

    localparam logic [7:0] REG_KICKS  = 8'(2 * NUM_ROUNDS);
    localparam logic [7:0] LAST_FRAME = 8'(RESULT_FRAMES - 1);

    logic [7:0] key_code;
    logic       key_edge;

    key_edge_detect u_key (
        .clk      (Clk),
        .rst_n    (reset_rtl_0),
        .keycode  (keycode),
        .key_code (key_code),
        .key_edge (key_edge)
    );

    game_state_e state_q, state_d;
    logic        kick_start_q, kick_start_d;
    logic [1:0]  aim_q, aim_d;
    logic [3:0]  score_a_q, score_a_d, score_b_q, score_b_d;
    logic        kicker_q, kicker_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  kick_cnt_q, kick_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  kc_next;
    logic        game_end;

    always_comb begin
        state_d      = state_q;
        kick_start_d = 1'b0;
        aim_d        = aim_q;
        score_a_d    = score_a_q;
        score_b_d    = score_b_q;
        kicker_d     = kicker_q;
        winner_d     = winner_q;
        kick_cnt_d   = kick_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        kc_next      = kick_cnt_q + 8'd1;
`ifdef PENALTY_SUDDEN_DEATH_EN
        game_end = (kc_next >= REG_KICKS) && !kc_next[0] && (score_a_q != score_b_q);
`else
        game_end = (kc_next == REG_KICKS);
`endif

        // Esc outranks everything, including a shot_done in the same cycle
        if (key_edge && key_code == KEY_ESC) begin
            state_d     = MENU;
            winner_d    = WIN_NONE;
            frame_cnt_d = 8'd0;
        end else begin
            case (state_q)
                MENU, GAME_OVER: begin
                    if (key_edge && key_code == KEY_ENTER) begin
                        state_d     = AIM;
                        aim_d       = AIM_CENTRE;
                        score_a_d   = 4'd0;
                        score_b_d   = 4'd0;
                        kicker_d    = 1'b0;
                        winner_d    = WIN_NONE;
                        kick_cnt_d  = 8'd0;
                        frame_cnt_d = 8'd0;
                    end
                end
                AIM: begin
                    if (key_edge) begin
                        if (key_code == KEY_LEFT) begin
                            aim_d = AIM_LEFT;
                        end else if (key_code == KEY_RIGHT) begin
                            aim_d = AIM_RIGHT;
                        end else if (key_code == KEY_SPACE) begin
                            kick_start_d = 1'b1;
                            state_d      = SHOOT;
                        end
                    end
                end
                SHOOT: begin
                    if (shot_done) begin
                        if (!save_detect) begin
                            if (!kicker_q && score_a_q != 4'hF) score_a_d = score_a_q + 4'd1;
                            if (kicker_q && score_b_q != 4'hF)  score_b_d = score_b_q + 4'd1;
                        end
                        frame_cnt_d = 8'd0;
                        state_d     = RESULT;
                    end
                end
                RESULT: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == LAST_FRAME) begin
                            frame_cnt_d = 8'd0;
                            kick_cnt_d  = kc_next;
                            kicker_d    = ~kicker_q;
                            aim_d       = AIM_CENTRE;
                            if (game_end) begin
                                state_d  = GAME_OVER;
                                winner_d = winner_of(score_a_q, score_b_q);
                            end else begin
                                state_d = AIM;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = MENU;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q      <= MENU;
            kick_start_q <= 1'b0;
            aim_q        <= AIM_CENTRE;
            score_a_q    <= 4'd0;
            score_b_q    <= 4'd0;
            kicker_q     <= 1'b0;
            winner_q     <= WIN_NONE;
            kick_cnt_q   <= 8'd0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            kick_start_q <= kick_start_d;
            aim_q        <= aim_d;
            score_a_q    <= score_a_d;
            score_b_q    <= score_b_d;
            kicker_q     <= kicker_d;
            winner_q     <= winner_d;
            kick_cnt_q   <= kick_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign game_state = state_q;
    assign kick_start = kick_start_q;
    assign aim_dir    = aim_q;
    assign score_a    = score_a_q;
    assign score_b    = score_b_q;
    assign kicker     = kicker_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_penalty_game_ctrl.sv
// tb/tb_penalty_game_ctrl.sv - scoreboard bench for penalty_game_ctrl (NUM_ROUNDS=1, RESULT_FRAMES=2)
module tb_penalty_game_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       ks;
        logic [1:0] aim;
        logic [3:0] sa;
        logic [3:0] sb;
        logic       k;
        logic [1:0] w;
    } obs_t;

    logic       Clk = 1'b0;
    logic       reset_rtl_0 = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic       frame_tick = 1'b0;
    logic       shot_done = 1'b0;
    logic       save_detect = 1'b0;
    logic [2:0] game_state;
    logic       kick_start;
    logic [1:0] aim_dir;
    logic [3:0] score_a, score_b;
    logic       kicker;
    logic [1:0] winner;

    penalty_game_ctrl #(.NUM_ROUNDS(1), .RESULT_FRAMES(2)) dut (
        .Clk         (Clk),
        .reset_rtl_0 (reset_rtl_0),
        .keycode     (keycode),
        .frame_tick  (frame_tick),
        .shot_done   (shot_done),
        .save_detect (save_detect),
        .game_state  (game_state),
        .kick_start  (kick_start),
        .aim_dir     (aim_dir),
        .score_a     (score_a),
        .score_b     (score_b),
        .kicker      (kicker),
        .winner      (winner)
    );

    always #5 Clk = ~Clk;

    int    vectors = 0;
    int    miscompares = 0;
    obs_t  exp_q[$];
    string name_q[$];
    obs_t  m;

    task automatic expect_now(input string name);
        exp_q.push_back(m);
        name_q.push_back(name);
    endtask

    // Monitor: every change of the observed output tuple consumes one expectation
    obs_t cur, prev;
    bit   first = 1'b1;
    always @(negedge Clk) begin
        cur = '{st: game_state, ks: kick_start, aim: aim_dir, sa: score_a,
                sb: score_b, k: kicker, w: winner};
        if (first || cur != prev) begin
            obs_t  e;
            string n;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: got st=%0d ks=%0d aim=%0d sa=%0d sb=%0d k=%0d w=%0d, want no change",
                         cur.st, cur.ks, cur.aim, cur.sa, cur.sb, cur.k, cur.w);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (cur != e) begin
                    miscompares++;
                    $display("FAIL %s: got st=%0d ks=%0d aim=%0d sa=%0d sb=%0d k=%0d w=%0d, want st=%0d ks=%0d aim=%0d sa=%0d sb=%0d k=%0d w=%0d",
                             n, cur.st, cur.ks, cur.aim, cur.sa, cur.sb, cur.k, cur.w,
                             e.st, e.ks, e.aim, e.sa, e.sb, e.k, e.w);
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        cyc(3);
        keycode = 8'd0;
        cyc(2);
    endtask

    task automatic shot(input logic s);
        shot_done   = 1'b1;
        save_detect = s;
        cyc(1);
        shot_done   = 1'b0;
        save_detect = 1'b0;
        cyc(2);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(2);
    endtask

    // Space in AIM: SHOOT with kick_start for one cycle, then kick_start low
    task automatic kick(input string name);
        m.st = 3'd2; m.ks = 1'b1; expect_now({name, "_kick_hi"});
        m.ks = 1'b0;              expect_now({name, "_kick_lo"});
        press(8'h2C);
    endtask

    task automatic finish_result(input string name);
        tick();
        tick();
    endtask

    initial begin
        m = '0;
        expect_now("reset");
        cyc(3);
        reset_rtl_0 = 1'b1;
        cyc(2);

        m.st = 3'd1; expect_now("enter_held");
        keycode = 8'h28;
        cyc(100);
        keycode = 8'd0;
        cyc(2);

        m.aim = 2'd1; expect_now("left");
        press(8'h50);
        press(8'h50);
        m.aim = 2'd2; expect_now("right");
        press(8'h4F);
        kick("a1");
        press(8'h50);

        m.st = 3'd3; m.sa = 4'd1; expect_now("a1_goal");
        shot(1'b0);
        m.st = 3'd1; m.aim = 2'd0; m.k = 1'b1; expect_now("a1_result_done");
        tick();
        tick();

        kick("b1");
        m.st = 3'd3; expect_now("b1_saved");
        shot(1'b1);
        m.st = 3'd4; m.k = 1'b0; m.w = 2'd1; expect_now("game_over_a");
        tick();
        tick();

        m = '0; m.st = 3'd1; expect_now("restart");
        press(8'h28);
        kick("t1");
        m.st = 3'd3; expect_now("t1_saved");
        shot(1'b1);
        m.st = 3'd1; m.k = 1'b1; expect_now("t1_done");
        tick(); tick();
        kick("t2");
        m.st = 3'd3; expect_now("t2_saved");
        shot(1'b1);
`ifdef PENALTY_SUDDEN_DEATH_EN
        m.st = 3'd1; m.k = 1'b0; expect_now("tie_continue");
        tick(); tick();
        kick("sd_a");
        m.st = 3'd3; m.sa = 4'd1; expect_now("sd_a_goal");
        shot(1'b0);
        m.st = 3'd1; m.k = 1'b1; expect_now("sd_a_done");
        tick(); tick();
        kick("sd_b");
        m.st = 3'd3; expect_now("sd_b_saved");
        shot(1'b1);
        m.st = 3'd4; m.k = 1'b0; m.w = 2'd1; expect_now("sd_winner_a");
        tick(); tick();
`else
        m.st = 3'd4; m.k = 1'b0; m.w = 2'd3; expect_now("tie_draw");
        tick(); tick();
`endif

        m.st = 3'd0; m.w = 2'd0; expect_now("esc_game_over");
        press(8'h29);
        shot(1'b0);

        m = '0; m.st = 3'd1; expect_now("enter_again");
        press(8'h28);
        m.aim = 2'd1; expect_now("left_again");
        press(8'h50);
        kick("e1");
        m.st = 3'd0; expect_now("esc_with_shot");
        keycode = 8'h29;
        cyc(1);
        shot_done = 1'b1;
        cyc(1);
        shot_done = 1'b0;
        keycode   = 8'd0;
        cyc(2);
        shot(1'b0);
        shot(1'b0);

        m = '0; m.st = 3'd1; expect_now("enter_pre_reset");
        press(8'h28);
        kick("r1");
        m.st = 3'd3; m.sa = 4'd1; expect_now("r1_goal");
        shot(1'b0);
        tick();
        m = '0; expect_now("async_reset");
        @(posedge Clk);
        #3 reset_rtl_0 = 1'b0;
        cyc(3);
        reset_rtl_0 = 1'b1;
        cyc(10);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expectations: got %0d outstanding, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
